// File: rtl/mpi_busmaster_if.sv
// Command-side and bus-pin signals of the MPI/Q-bus master.
// The master modport is the engine's view; the slave modport is the CPU/bus environment's view.
interface mpi_busmaster_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
) ();
  logic          cmd_valid;
  logic          cmd_we;
  logic          cmd_byte;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_dout;
  logic [DW-1:0] bus_din;
  logic          bsync;
  logic          bdin;
  logic          bdout;
  logic          bwtbt;
  logic          bbsy;
  logic          brply;

  modport master (
    input  cmd_valid, cmd_we, cmd_byte, cmd_addr, cmd_wdata, bus_din, brply,
    output cmd_ready, done, err, rdata, bus_addr, bus_dout, bsync, bdin, bdout, bwtbt, bbsy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_byte, cmd_addr, cmd_wdata, bus_din, brply,
    input  cmd_ready, done, err, rdata, bus_addr, bus_dout, bsync, bdin, bdout, bwtbt, bbsy
  );
endinterface

// File: rtl/mpi_busmaster.sv
// Registered SYNC/DIN/DOUT handshake engine for the MPI/Q-bus.
// Define BUS_TIMEOUT_EN to compile in the RPLY timeout counters and the ERROR state.
module mpi_busmaster #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned SETUP   = 1,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  mpi_busmaster_if.master   mpi
);

  localparam int unsigned SetupW = (SETUP > 1) ? $clog2(SETUP) : 1;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {StIdle, StAddr, StData, StRelease, StError} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAddr, StData, StRelease} state_e;
`endif

  state_e              state_q, state_d;
  logic [SetupW-1:0]   setup_cnt_q, setup_cnt_d;
`ifdef BUS_TIMEOUT_EN
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
`else
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  logic          cmd_ready_q, cmd_ready_d;
  logic          done_q, done_d;
  logic          bsync_q, bsync_d;
  logic          bdin_q, bdin_d;
  logic          bdout_q, bdout_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // State register: everything holds while ce is low; reset wins regardless of ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      setup_cnt_q <= '0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      bsync_q     <= 1'b0;
      bdin_q      <= 1'b0;
      bdout_q     <= 1'b0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
`endif
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      bsync_q     <= bsync_d;
      bdin_q      <= bdin_d;
      bdout_q     <= bdout_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
`ifdef BUS_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (mpi.cmd_valid) begin
          state_d     = StAddr;
          setup_cnt_d = SetupW'(SETUP - 1);
        end
      end
      StAddr: begin
        if (setup_cnt_q != '0) begin
          setup_cnt_d = setup_cnt_q - 1'b1;
        end else begin
          state_d = StData;
`ifdef BUS_TIMEOUT_EN
          to_cnt_d = ToW'(TIMEOUT);
`endif
        end
      end
      StData: begin
        // RPLY is checked first so that it beats a simultaneous expiry.
        if (mpi.brply) begin
          state_d = StRelease;
`ifdef BUS_TIMEOUT_EN
          to_cnt_d = ToW'(TIMEOUT);
        end else if (to_cnt_q == '0) begin
          state_d = StError;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
`endif
        end
      end
      StRelease: begin
        if (!mpi.brply) begin
          state_d = StIdle;
`ifdef BUS_TIMEOUT_EN
        end else if (to_cnt_q == '0) begin
          state_d = StError;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
`endif
        end
      end
`ifdef BUS_TIMEOUT_EN
      StError: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath next values; every output comes straight from a register.
  always_comb begin
    logic accept;
    accept      = (state_q == StIdle) && mpi.cmd_valid;
    cmd_ready_d = (state_d == StIdle);
    bsync_d     = (state_d != StIdle);
    done_d      = (state_q != StIdle) && (state_d == StIdle);
`ifdef BUS_TIMEOUT_EN
    err_d       = (state_q == StError);
    // A strobe survives into ERROR only if it was up in DATA; ERROR then drops it.
    bdin_d      = ((state_d == StData) && !we_q) || ((state_d == StError) && bdin_q);
    bdout_d     = ((state_d == StData) && we_q) || ((state_d == StError) && bdout_q);
`else
    bdin_d      = (state_d == StData) && !we_q;
    bdout_d     = (state_d == StData) && we_q;
`endif
    we_d        = accept ? mpi.cmd_we : we_q;
    byte_d      = accept ? mpi.cmd_byte : byte_q;
    addr_d      = accept ? mpi.cmd_addr : addr_q;
    wdata_d     = accept ? mpi.cmd_wdata : wdata_q;
    rdata_d     = ((state_q == StData) && mpi.brply && !we_q) ? mpi.bus_din : rdata_q;
  end

  assign mpi.cmd_ready = cmd_ready_q;
  assign mpi.done      = done_q;
`ifdef BUS_TIMEOUT_EN
  assign mpi.err       = err_q;
`else
  assign mpi.err       = 1'b0;
`endif
  assign mpi.rdata     = rdata_q;
  assign mpi.bus_addr  = addr_q;
  assign mpi.bus_dout  = wdata_q;
  assign mpi.bsync     = bsync_q;
  assign mpi.bdin      = bdin_q;
  assign mpi.bdout     = bdout_q;
  assign mpi.bwtbt     = byte_q;
  assign mpi.bbsy      = bsync_q;

endmodule

// File: doc/mpi_busmaster.md
# mpi_busmaster

Parametrised bus master for the CPU's asynchronous MPI/Q-bus interface. It replaces the combinational SYNC/DIN/DOUT mapping with a registered handshake engine. The engine has programmable address setup, a bounded wait for RPLY, a full RPLY-release phase and bus-error signalling. It sits between the CPU control unit (command side) and the external bus pins (SYNC, DIN, DOUT, WTBT, BSY, RPLY).

## Interface
Parameters:
- `DW`, 16: data width.
- `AW`, 16: address width.
- `SETUP`, 1: ce-cycles from SYNC rising to DIN/DOUT rising (≥1).
- `TIMEOUT`, 63: ce-cycles to wait for RPLY before bus error; counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: clock enable; state advances only on clk edges with ce=1.
- `cmd_valid` in 1: command request.
- `cmd_we` in 1: 1 = DATO (write), 0 = DATI (read).
- `cmd_byte` in 1: byte transfer.
- `cmd_addr` in AW: transfer address.
- `cmd_wdata` in DW: write data.
- `cmd_ready` out 1: engine idle, command accepted this ce-cycle.
- `done` out 1: one-ce-cycle completion pulse.
- `err` out 1: qualifies `done`; transfer ended by timeout.
- `rdata` out DW: read data, held until the next read completes.
- `bus_addr` out AW: latched address.
- `bus_dout` out DW: latched write data.
- `bus_din` in DW: bus read data.
- `bsync` out 1: SYNC.
- `bdin` out 1: DIN.
- `bdout` out 1: DOUT.
- `bwtbt` out 1: WTBT, equal to the latched `cmd_byte`.
- `bbsy` out 1: BSY, equal to `bsync`.
- `brply` in 1: RPLY, already synchronous to clk.

## Operation
States: IDLE, ADDR, DATA, RELEASE, ERROR.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`:
  - latch addr, wdata, we, byte;
  - set `bsync`=1 and setup counter = SETUP−1;
  - go to ADDR.
- **ADDR:** if counter≠0, decrement. Else:
  - assert `bdin` (read) or `bdout` (write);
  - load timeout counter = TIMEOUT;
  - go to DATA.
- **DATA:** if `brply`:
  - read: capture `bus_din` into `rdata`;
  - drop `bdin`/`bdout`;
  - go to RELEASE.
  - Else if timeout counter = 0, go to ERROR. Else decrement.
- **RELEASE:** wait for `brply`=0, then:
  - drop `bsync`;
  - pulse `done`;
  - go to IDLE.
  - Timeout counter is reloaded on entry and reused; expiry goes to ERROR.
- **ERROR:** drop `bsync`/`bdin`/`bdout`, pulse `done`+`err`, go to IDLE. `rdata` is unchanged.

Behaviour rules:
- `cmd_valid` outside IDLE is ignored, so the caller must hold it until `cmd_ready`.
- Latched addr/data are stable from acceptance until return to IDLE.
- `bdin` and `bdout` are never high together. Neither is high without `bsync`.

## Timing
- Reset values: all outputs 0 except `cmd_ready`=1. `bus_addr`, `bus_dout` and `rdata` = 0. State = IDLE.
- Reset mid-transfer: all bus strobes low after the same edge; no `done`.
- All outputs are registered. Edges below count ce-edges from the acceptance edge E0.
  - `bsync` is high after E0.
  - `bdin`/`bdout` is high after E(SETUP).
- Earliest RPLY sampled at E(SETUP+1) gives:
  - `rdata` valid and strobe low after that edge;
  - if RPLY is low at E(SETUP+2), `bsync` low and `done`=1 after E(SETUP+2).
- Minimum transfer is SETUP+3 ce-edges, including the IDLE cycle.
- Timeout: with no RPLY, `err`/`done` are high after E(SETUP+TIMEOUT+2).
- TIMEOUT=0: errors on the first DATA cycle without RPLY.
- RPLY arriving on the expiry edge takes priority over timeout.
- `done` lasts one ce-cycle. The next command can be accepted on the edge after `done` (the IDLE cycle).
- With ce=0 all state and outputs hold.

## Configuration
- `BUS_TIMEOUT_EN` defined: timeout counters and the ERROR state are compiled in, as specified above.
- `BUS_TIMEOUT_EN` undefined:
  - counters and ERROR are removed;
  - DATA and RELEASE wait indefinitely;
  - `err` is tied to 0.
  - TIMEOUT is ignored.

## Test plan
- Read, SETUP=1, addr 0o177716. Slave returns 0o123456 with RPLY one cycle after DIN. Require:
  - SYNC before DIN by exactly 1 ce-cycle;
  - `rdata`=0o123456;
  - `done`=1, `err`=0;
  - `bsync`=0 after RPLY drops.
- Byte write 0o000377 to 0o001001:
  - `bwtbt`=1 throughout;
  - `bus_dout`=0o000377 and `bdout` held until RPLY;
  - `bdin` never asserted.
- With `BUS_TIMEOUT_EN`, TIMEOUT=63, no RPLY:
  - `done`=`err`=1 exactly SETUP+65 ce-edges after acceptance;
  - all strobes low;
  - `rdata` unchanged.
- RPLY held high for 5 extra cycles after DIN drops:
  - `bsync` stays high until RPLY falls;
  - `done` follows one edge later.
- Back-to-back: `cmd_valid` held high for two commands. Require:
  - second accepted only on `cmd_ready`;
  - ce toggling 1/0 stretches all timings 2×.
- Assert `reset` while in DATA:
  - all strobes 0 and `cmd_ready`=1 next edge;
  - no `done` pulse.
